axi_master: RTL and testbench

AXI_MASTER -- requirements
Module: axi_master

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_wbuf.sv | 63 ++++++
 rtl/axi_master.sv | 183 ++++++++++++++++++
 tb/tb_axi_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared FSM encoding and AXI burst codes for the simple AXI master.
// No timing of its own; types only.
// No flow control of its own.
package axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_wbuf.sv
// W-channel output register: one user write beat staged toward the AXI slave.
// Latency: one cycle from the user handshake to wvalid.
// Backpressure: a beat holds until wready; wr_ready stays low while full or all beats taken.
module axi_wbuf #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              i_active,
    input  logic              i_clr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic              i_wready,
    output logic              o_wvalid,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wlast,
    output logic              o_last_hs
);

    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    logic [LEN_W:0]    r_cnt;
    logic              r_wvalid;
    logic              r_wlast;
    logic [DATA_W-1:0] r_wdata;
    logic [LEN_W:0]    w_len_ext;
    logic              w_load;

    assign w_len_ext  = {1'b0, i_len};
    // beats accepted < len+1, written as <= len to keep widths equal
    assign o_wr_ready = i_active & (~r_wvalid | i_wready) & (r_cnt <= w_len_ext);
    assign w_load     = i_wr_valid & o_wr_ready;
    assign o_wvalid   = r_wvalid;
    assign o_wdata    = r_wdata;
    assign o_wlast    = r_wlast;
    assign o_last_hs  = r_wvalid & r_wlast & i_wready;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_cnt    <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_wdata  <= '0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end
            if (w_load) begin
                r_wdata  <= i_wr_data;
                r_wvalid <= 1'b1;
                r_wlast  <= (r_cnt == w_len_ext);
                r_cnt    <= r_cnt + CNT_ONE;
            end else if (r_wvalid && i_wready) begin
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_master.sv
// Single-outstanding AXI master: one user command becomes one AR/R or AW/W/B burst.
// Latency: address one cycle after accept, done one cycle after last R or B handshake.
// Backpressure: address held until ready; R passes rd_ready through; W via axi_wbuf.
module axi_master
    import axi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic              done_err,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rresp,
    input  logic              rlast,
    output logic              rready,
    output logic              awvalid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    input  logic              awready,
    output logic              wvalid,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    input  logic              wready,
    input  logic              bvalid,
    input  logic              bresp,
    output logic              bready
);

    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [LEN_W:0]    r_cnt;
    logic              r_err;
    logic              w_cmd_acc;
    logic              w_wactive;
    logic              w_last_hs;
    logic              w_rbeat;

    assign w_cmd_acc = cmd_valid & cmd_ready;
    assign w_rbeat   = (r_state == ST_R) & rvalid & rd_ready;

    assign araddr  = r_addr;
    assign arlen   = r_len;
    assign arsize  = r_size;
    assign arburst = r_burst;
    assign awaddr  = r_addr;
    assign awlen   = r_len;
    assign awsize  = r_size;
    assign awburst = r_burst;

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        arvalid   = 1'b0;
        awvalid   = 1'b0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        bready    = 1'b0;
        done      = 1'b0;
        done_err  = 1'b0;
        w_wactive = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // keeps cmd_ready low for as long as reset is held
                cmd_ready = res_n;
                if (cmd_valid) begin
                    w_next = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) w_next = ST_R;
            end
            ST_R: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_data  = rdata;
                if (rvalid && rd_ready && rlast) w_next = ST_DONE;
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) w_next = ST_W;
            end
            ST_W: begin
                w_wactive = 1'b1;
                if (w_last_hs) w_next = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) w_next = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                done_err = r_err;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cmd_acc) begin
                r_addr  <= cmd_addr;
                r_len   <= cmd_len;
                r_size  <= cmd_size;
                r_burst <= cmd_burst;
                r_cnt   <= '0;
                r_err   <= 1'b0;
            end
            if (w_rbeat) begin
                r_cnt <= r_cnt + CNT_ONE;
                // rlast arriving on any beat other than index len is a length mismatch
                if (rresp || (rlast && (r_cnt != {1'b0, r_len}))) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == ST_B) && bvalid && bresp) begin
                r_err <= 1'b1;
            end
        end
    end

    axi_wbuf #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_wbuf (
        .clk        (clk),
        .res_n      (res_n),
        .i_active   (w_wactive),
        .i_clr      (w_cmd_acc),
        .i_len      (r_len),
        .i_wr_data  (wr_data),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wready   (wready),
        .o_wvalid   (wvalid),
        .o_wdata    (wdata),
        .o_wlast    (wlast),
        .o_last_hs  (w_last_hs)
    );

endmodule

// File: tb/tb_axi_master.sv
// Self-checking bench for axi_master: table of bursts against a memory-backed slave model,
// plus reset-state and mid-burst reset sequences.
module tb_axi_master;

    logic        clk = 1'b0;
    logic        res_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready;
    logic        done, done_err;
    logic        arvalid, arready;
    logic [4:0]  araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rresp, rlast, rready;
    logic [15:0] rdata;
    logic        awvalid, awready;
    logic [4:0]  awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wlast, wready;
    logic [15:0] wdata;
    logic        bvalid, bresp, bready;

    always #5 clk = ~clk;

    axi_master dut (
        .clk(clk), .res_n(res_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_err(done_err),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [3:0]  len;
        logic [15:0] d[4];
        int          dly;
        bit          tog;
        int          wstall;
        int          rresp_at;
        int          rlast_at;
        bit          bresp;
        bit          eerr;
    } vec_t;

    vec_t        vt[11];
    logic [15:0] mem[32];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic setv(input int k, input bit wr, input logic [4:0] addr, input logic [3:0] len,
                        input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] d3, input int dly, input bit tog, input int wstall,
                        input int rresp_at, input int rlast_at, input bit br, input bit eerr);
        vt[k].wr = wr; vt[k].addr = addr; vt[k].len = len;
        vt[k].d[0] = d0; vt[k].d[1] = d1; vt[k].d[2] = d2; vt[k].d[3] = d3;
        vt[k].dly = dly; vt[k].tog = tog; vt[k].wstall = wstall;
        vt[k].rresp_at = rresp_at; vt[k].rlast_at = rlast_at;
        vt[k].bresp = br; vt[k].eerr = eerr;
    endtask

    function automatic logic [15:0] beat_dat(input vec_t t, input int i);
        return (i < 4) ? t.d[i] : 16'(32'h1000 + i);
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    task automatic run_txn(input vec_t t, input string nm);
        int last_eff;
        int wi = 0, wb = 0, rb = 0, acnt = 0, stl = 0;
        bit addr_ok = 0, bpend = 0, fin = 0;
        logic [15:0] q[$];
        logic [15:0] e;
        last_eff = (t.rlast_at >= 0) ? t.rlast_at : int'(t.len);
        @(negedge clk);
        cmd_valid = 1; cmd_write = t.wr; cmd_addr = t.addr; cmd_len = t.len;
        cmd_size = 3'd1; cmd_burst = 2'b01;
        #1 chk({nm, " cmd_ready"}, cmd_ready, 1);
        if (!t.wr)
            for (int i = 0; i <= last_eff; i++) q.push_back(mem[5'(int'(t.addr) + i)]);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 0;
            wr_valid  = t.wr && (wi <= int'(t.len));
            wr_data   = beat_dat(t, wi);
            arready   = (acnt >= t.dly);
            awready   = (acnt >= t.dly);
            rvalid    = addr_ok && !t.wr && (rb <= last_eff);
            rdata     = mem[5'(int'(t.addr) + rb)];
            rlast     = (rb == last_eff);
            rresp     = (rb == t.rresp_at);
            rd_ready  = t.tog ? (cyc % 2 == 0) : 1'b1;
            wready    = !(wb == 2 && stl < t.wstall);
            bvalid    = bpend;
            bresp     = t.bresp;
            #1;
            if (arvalid || awvalid) begin
                chk({nm, " chan"}, awvalid, t.wr);
                chk({nm, " addr"}, t.wr ? awaddr : araddr, t.addr);
                chk({nm, " len"}, t.wr ? awlen : arlen, t.len);
                chk({nm, " size/burst"}, t.wr ? {awsize, awburst} : {arsize, arburst}, 5'b001_01);
                if ((arvalid && arready) || (awvalid && awready)) addr_ok = 1;
                acnt++;
            end
            if (rvalid) begin
                chk({nm, " rd_valid"}, rd_valid, 1);
                chk({nm, " rready"}, rready, rd_ready);
            end
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) chk({nm, " extra rd beat"}, 1, 0);
                else begin
                    e = q.pop_front();
                    chk({nm, " rd_data"}, rd_data, e);
                end
            end
            if (rvalid && rready) rb++;
            if (wvalid && !wready) begin
                stl++;
                chk({nm, " wr_ready stalled"}, wr_ready, 0);
                chk({nm, " wlast held"}, wlast, wb == int'(t.len));
                if (q.size() != 0) chk({nm, " wdata held"}, wdata, q[0]);
            end
            if (bvalid) begin
                chk({nm, " bready"}, bready, 1);
                if (bready) bpend = 0;
            end
            if (wvalid && wready) begin
                if (q.size() == 0) chk({nm, " extra w beat"}, 1, 0);
                else begin
                    e = q.pop_front();
                    chk({nm, " wdata"}, wdata, e);
                end
                chk({nm, " wlast"}, wlast, wb == int'(t.len));
                mem[5'(int'(t.addr) + wb)] = wdata;
                if (wlast) bpend = 1;
                wb++;
            end
            if (wr_valid && wr_ready) begin
                q.push_back(beat_dat(t, wi));
                wi++;
            end
            if (done) begin
                fin = 1;
                chk({nm, " done_err"}, done_err, t.eerr);
                chk({nm, " cmd_ready in done"}, cmd_ready, 0);
                chk({nm, " leftover beats"}, q.size(), 0);
                chk({nm, " beat count"}, t.wr ? wb : rb, t.wr ? int'(t.len) + 1 : last_eff + 1);
            end
        end
        chk({nm, " timeout"}, fin, 1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({nm, " done pulse width"}, done, 0);
        chk({nm, " cmd_ready after done"}, cmd_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        setv(0,  1, 5'd0,  4'd3,  16'hff11, 16'h11aa, 16'h0011, 16'h1110, 0, 0, 0, -1, -1, 0, 0);
        setv(1,  0, 5'd0,  4'd3,  16'h0, 16'h0, 16'h0, 16'h0,             0, 0, 0, -1, -1, 0, 0);
        setv(2,  0, 5'd0,  4'd3,  16'h0, 16'h0, 16'h0, 16'h0,             3, 1, 0, -1, -1, 0, 0);
        setv(3,  1, 5'd4,  4'd3,  16'ha1a1, 16'hb2b2, 16'hc3c3, 16'hd4d4, 0, 0, 2, -1, -1, 0, 0);
        setv(4,  0, 5'd4,  4'd3,  16'h0, 16'h0, 16'h0, 16'h0,             0, 0, 0,  2, -1, 0, 1);
        setv(5,  1, 5'd9,  4'd0,  16'h5a5a, 16'h0, 16'h0, 16'h0,          0, 0, 0, -1, -1, 0, 0);
        setv(6,  0, 5'd9,  4'd0,  16'h0, 16'h0, 16'h0, 16'h0,             0, 0, 0, -1, -1, 0, 0);
        setv(7,  1, 5'd16, 4'd15, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 1, 0, 0, -1, -1, 0, 0);
        setv(8,  0, 5'd16, 4'd15, 16'h0, 16'h0, 16'h0, 16'h0,             1, 1, 0, -1, -1, 0, 0);
        setv(9,  1, 5'd2,  4'd1,  16'h3c3c, 16'hc3c3, 16'h0, 16'h0,       0, 0, 0, -1, -1, 1, 1);
        setv(10, 0, 5'd0,  4'd3,  16'h0, 16'h0, 16'h0, 16'h0,             0, 0, 0, -1,  1, 0, 1);

        idle_inputs();
        res_n = 0;
        #1;
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset valids", {arvalid, awvalid, wvalid, rd_valid, done}, 5'b0);
        chk("reset readies", {rready, bready, wr_ready, done_err}, 4'b0);
        repeat (3) @(negedge clk);
        res_n = 1;
        #1 chk("cmd_ready after release", cmd_ready, 1);

        for (int k = 0; k < 11; k++) run_txn(vt[k], $sformatf("vec%0d", k));

        // reset in the middle of the second W beat
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 5'd24; cmd_len = 4'd3;
        cmd_size = 3'd1; cmd_burst = 2'b01;
        @(negedge clk);
        cmd_valid = 0; awready = 1; wready = 1; wr_valid = 1; wr_data = 16'h0001;
        begin
            bit seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                #1;
                if (wvalid && wdata == 16'h0002) seen = 1;
                else if (wr_ready) wr_data = wr_data + 16'h0001;
            end
            chk("rst: reached beat 2", seen, 1);
        end
        res_n = 0;
        #1;
        chk("rst: wvalid", wvalid, 0);
        chk("rst: other valids", {awvalid, arvalid, rd_valid, done}, 4'b0);
        chk("rst: readies", {cmd_ready, wr_ready, rready, bready}, 4'b0);
        idle_inputs();
        @(negedge clk);
        res_n = 1;
        #1;
        chk("rst: cmd_ready first idle", cmd_ready, 1);
        @(negedge clk);
        #1;
        chk("rst: still idle", {cmd_ready, awvalid, wvalid}, 3'b100);
        run_txn(vt[1], "post-reset read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
